// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer and its ALU decoder.
package mdu_pkg;

   typedef enum logic [1:0] {
      MUL   = 2'b00,
      MULHU = 2'b01,
      DIVU  = 2'b10,
      REMU  = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } mdu_state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

endpackage

// File: rtl/mdu_sequencer.sv
// Unsigned MUL/MULHU/DIVU/REMU by borrowing the shared ALU for one ADD or SUB per cycle
// (shift-add multiply, restoring divide); shifts, carry and compare are local.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int ITER    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_op,
   input  logic [D_WIDTH-1:0] in_a,
   input  logic [D_WIDTH-1:0] in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [D_WIDTH-1:0] out_result,
   output logic               busy,
   output logic               alu_own,
   output logic [3:0]         alu_ctrl,
   output logic               alu_src,
   output logic [D_WIDTH-1:0] alu_op1,
   output logic [D_WIDTH-1:0] alu_op2,
   input  logic [D_WIDTH-1:0] alu_result
);

   localparam logic [5:0] LP_LAST = 6'(ITER - 1);

   mdu_state_t          r_state, w_state_nxt;
   mdu_op_t             r_op;
   logic [D_WIDTH-1:0]  r_hi;      // product high word / partial remainder
   logic [D_WIDTH-1:0]  r_lo;      // multiplier shifting out / quotient shifting in
   logic [D_WIDTH-1:0]  r_b;       // multiplicand / divisor
   logic [5:0]          r_cnt;
   logic [D_WIDTH-1:0]  r_result;

   logic                w_accept, w_div0, w_last, w_is_div;
   logic                w_carry, w_take;
   logic [D_WIDTH-1:0]  w_sh, w_hi_nxt, w_lo_nxt;

   assign w_accept = in_valid && (r_state == IDLE);
   assign w_div0   = in_op[1] && (in_b == '0);
   assign w_last   = (r_cnt == LP_LAST);
   assign w_is_div = r_op[1];

   assign in_ready   = (r_state == IDLE);
   assign out_valid  = (r_state == DONE);
   assign busy       = (r_state == RUN) || (r_state == DONE);
   assign alu_own    = (r_state == RUN);
   assign alu_src    = 1'b0;
   assign out_result = r_result;

   always_comb begin
      w_sh     = {r_hi[D_WIDTH-2:0], r_lo[D_WIDTH-1]};
      w_carry  = (alu_result < r_hi);
      // Remainder bit shifted out the top means sh already exceeds any divisor.
      w_take   = r_hi[D_WIDTH-1] || (w_sh >= r_b);
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      alu_ctrl = ALU_ADD;
      alu_op1  = '0;
      alu_op2  = '0;
      if (r_state == RUN) begin
         alu_op2 = r_b;
         if (w_is_div) begin
            alu_ctrl = ALU_SUB;
            alu_op1  = w_sh;
            w_hi_nxt = w_take ? alu_result : w_sh;
            w_lo_nxt = {r_lo[D_WIDTH-2:0], w_take};
         end else begin
            alu_op1 = r_hi;
            if (r_lo[0]) begin
               w_hi_nxt = {w_carry, alu_result[D_WIDTH-1:1]};
               w_lo_nxt = {alu_result[0], r_lo[D_WIDTH-1:1]};
            end else begin
               w_hi_nxt = {1'b0, r_hi[D_WIDTH-1:1]};
               w_lo_nxt = {r_hi[0], r_lo[D_WIDTH-1:1]};
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = w_div0 ? DONE : RUN;
         RUN:     if (w_last) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= MUL;
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_op  <= mdu_op_t'(in_op);
         r_hi  <= '0;
         r_lo  <= in_a;
         r_b   <= in_b;
         r_cnt <= '0;
         if (w_div0) r_result <= in_op[0] ? in_a : '1;
      end else if (r_state == RUN) begin
         r_hi  <= w_hi_nxt;
         r_lo  <= w_lo_nxt;
         r_cnt <= r_cnt + 6'd1;
         // Odd ops (MULHU, REMU) take the high/remainder word.
         if (w_last) r_result <= r_op[0] ? w_hi_nxt : w_lo_nxt;
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a behavioural ADD/SUB ALU closing the alu_* loop.
module tb_mdu_sequencer;

   logic        clk, rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, busy, alu_own, alu_src;
   logic [1:0]  in_op;
   logic [31:0] in_a, in_b, out_result, alu_op1, alu_op2, alu_result;
   logic [3:0]  alu_ctrl;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   mdu_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .busy(busy), .alu_own(alu_own), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result)
   );

   assign alu_result = (alu_ctrl == 4'b1000) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int w;
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op    = 2'(~op);
      in_a     = $urandom;
      in_b     = $urandom;
   endtask

   // Called right after the accepting edge; counts cycles until out_valid.
   task automatic wait_result(input string name, input logic [31:0] exp, input int lat);
      int cyc, own;
      bit got;
      cyc = 0; own = 0; got = 0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (alu_own) own++;
         if (out_valid) got = 1;
      end
      if (!got) chk({name, "_timeout"}, 32'(got), 32'd1);
      chk({name, "_result"}, out_result, exp);
      chk({name, "_latency"}, 32'(cyc), 32'(lat));
      chk({name, "_alu_own_cycles"}, 32'(own), (lat == 33) ? 32'd32 : 32'd0);
      if (out_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         33};
      vecs[1]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   33};
      vecs[2]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   33};
      vecs[3]  = '{2'b10, 32'd100,        32'd7,          32'd14,         33};
      vecs[4]  = '{2'b11, 32'd100,        32'd7,          32'd2,          33};
      vecs[5]  = '{2'b10, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33};
      vecs[6]  = '{2'b10, 32'h1234,       32'd0,          32'hFFFFFFFF,   1};
      vecs[7]  = '{2'b11, 32'h1234,       32'd0,          32'h1234,       1};
      vecs[8]  = '{2'b01, 32'h80000000,   32'd4,          32'd2,          33};
      vecs[9]  = '{2'b11, 32'hFFFFFFFF,   32'h10,         32'hF,          33};
      vecs[10] = '{2'b10, 32'hFFFFFFFF,   32'h80000000,   32'd1,          33};

      rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b1;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_own", 32'(alu_own), 32'd0);
      chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
      chk("rst_alu_op1", alu_op1, 32'd0);
      chk("rst_alu_op2", alu_op2, 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         start(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_result($sformatf("vec%0d", i), vecs[i].res, vecs[i].lat);
         chk($sformatf("vec%0d_idle_after", i), 32'(in_ready), 32'd1);
      end

      // Backpressure: result held through 5 stalled cycles.
      out_ready = 1'b0;
      start(2'b00, 32'd3, 32'd5);
      wait_result("bp_mul", 32'd15, 33);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_result", out_result, 32'd15);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = 2'b10;
      in_a      = 32'd20;
      in_b      = 32'd4;
      @(posedge clk);
      #1;
      chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
      chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_result("bp_second", 32'd5, 33);

      // Reset in the middle of a multiply, at cnt=10.
      start(2'b00, 32'h12345, 32'h6789);
      repeat (11) @(negedge clk);
      chk("mid_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_alu_own", 32'(alu_own), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      start(2'b10, 32'd9, 32'd3);
      wait_result("post_rst_div", 32'd3, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
